lsu_mem_handshake: RTL and testbench
====================================

Name: lsu_mem_handshake

Overview:
- Parametrised load/store unit that replaces the CPU's single-cycle, always-ready data-memory port with a valid/ready handshake to a variable-latency memory.
- Sits between the MEM stage and data memory. Performs byte-lane alignment, byte-enable generation and load sign/zero extension.
- Generates the stall that freezes the pipeline (PC enable, IF/ID enable) while an access is outstanding.
- Adds misalignment detection and a bounded-wait timeout, which the current fixed-latency port does not have.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, memory data width; 32 or 64 only. BYTES = DATA_W/8, LB = log2(BYTES).
- TIMEOUT, 255, maximum cycles waiting for mem_ready_i before abort; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  MEM stage holds a load or store.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend load (LBU/LHU).
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  store data, LSB-aligned.
- stall_o  out  1  freeze pipeline (drives PC enable and IF/ID enable low).
- rdata_o  out  DATA_W  aligned, extended load result.
- rdata_valid_o  out  1  rdata_o valid this cycle.
- misaligned_o  out  1  one-cycle pulse: misaligned or illegal request dropped.
- timeout_o  out  1  one-cycle pulse: access aborted by timeout.
- mem_valid_o  out  1  request to memory.
- mem_addr_o  out  ADDR_W  address with low LB bits zeroed.
- mem_we_o  out  BYTES  byte write enables; all zero for loads.
- mem_wdata_o  out  DATA_W  lane-shifted store data.
- mem_ready_i  in  1  memory accepts the request / returns read data.
- mem_rdata_i  in  DATA_W  read data, valid with mem_ready_i.

Behaviour:
- Reset: async on rst_n = 0. State IDLE, timeout counter 0, all outputs 0.
- Definitions:
  - lane = req_addr_i[LB-1:0].
  - misaligned = (size 01 & addr[0]) | (size 10 & addr[1:0] != 0) | (size 11).
  - accept = IDLE & req_valid_i & !misaligned.
- State IDLE:
  - On accept: register addr/we/size/unsigned/lane.
  - mem_we_o <= (size mask 1/3/15) << lane when storing, else 0.
  - mem_wdata_o <= wdata << 8·lane.
  - Go to REQ.
  - req_valid_i & misaligned: no memory access, no stall; misaligned_o = 1 the next cycle; stay IDLE.
- State REQ:
  - mem_valid_o = 1; addr/we/wdata held stable until handshake.
  - Handshake on mem_valid_o & mem_ready_i:
    - Load: capture mem_rdata_i >> 8·lane, extend per size/unsigned (byte → bit 7, half → bit 15, word → bit 31 for DATA_W = 64).
    - Go to RESP.
  - Counter increments each REQ cycle without ready. If counter == TIMEOUT−1 and !mem_ready_i: abort, mem_valid_o drops, go to RESP with timeout flag.
  - mem_ready_i in the same cycle as the timeout limit: ready wins, no timeout.
- State RESP (exactly one cycle):
  - stall_o = 0.
  - Normal load: rdata_valid_o = 1. Store: rdata_valid_o = 0.
  - Timeout: timeout_o = 1, rdata_o = 0, rdata_valid_o = 0.
  - Return to IDLE; counter cleared. RESP never starts a new access even if req_valid_i is still high.
- stall_o (combinational) = accept | (state == REQ). The pipeline freezes in the same cycle the request is seen.
- Latency: minimum 3 cycles, request to RESP (IDLE → REQ → RESP) with mem_ready_i high on the first REQ cycle.
- mem_ready_i outside REQ is ignored.
- rdata_o holds its last value outside RESP.
- Reset mid-access: immediate return to IDLE, mem_valid_o = 0, no pulses.

Test Plan:
- Load word, addr 0x100, memory returns 0xDEADBEEF with ready on first REQ cycle → mem_addr_o = 0x100, mem_we_o = 0000, stall_o high 2 cycles, RESP rdata_o = 0xDEADBEEF with rdata_valid_o = 1.
- Store byte 0xA5 to addr 0x203 → mem_addr_o = 0x200, mem_we_o = 1000, mem_wdata_o = 0xA5000000, rdata_valid_o = 0.
- LB at 0x302 with memory word 0x12F45678 → rdata_o = 0xFFFFFFF4. LBU same access → 0x000000F4. LHU at 0x302 → 0x000012F4.
- LH at addr 0x401 → misaligned_o pulse, mem_valid_o never asserted, stall_o stays 0.
- TIMEOUT = 4, mem_ready_i held low → mem_valid_o high 4 cycles, then timeout_o pulse, rdata_o = 0, IDLE. Repeat with ready on the 4th REQ cycle → normal completion, no timeout_o.
- rst_n low during REQ → mem_valid_o and stall_o drop immediately. After release, a new load completes normally.

Source files
------------

// File: rtl/lsu_mem_handshake_if.sv
// lsu_mem_handshake_if: valid/ready data-memory bus between the LSU (master) and memory (slave)
// mem_valid/mem_addr/mem_we/mem_wdata: request, driven by the master
// mem_ready/mem_rdata: accept strobe and read data, driven by the slave
interface lsu_mem_handshake_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_valid;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;
  modport master (output mem_valid, mem_addr, mem_we, mem_wdata, input mem_ready, mem_rdata);
  modport slave (input mem_valid, mem_addr, mem_we, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_mem_handshake.sv
// lsu_mem_handshake: load/store unit bridging the MEM stage to a variable-latency valid/ready memory
// clk, rst_n (async, active-low)
// req_*_i: MEM-stage access (valid, we, size, unsigned, addr, wdata)
// stall_o: pipeline freeze; rdata_o/rdata_valid_o: aligned, extended load result
// misaligned_o/timeout_o: one-cycle error pulses; mem: master side of the memory bus
module lsu_mem_handshake #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  input  logic               req_we_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_unsigned_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [DATA_W-1:0]  req_wdata_i,
  output logic               stall_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rdata_valid_o,
  output logic               misaligned_o,
  output logic               timeout_o,
  lsu_mem_handshake_if.master mem
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [LB-1:0]     lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTES-1:0]  mem_we_q, mem_we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              rv_q, rv_d, mis_q, mis_d, to_q, to_d;
  logic [LB-1:0]     lane;
  logic [BYTES-1:0]  mask;
  logic [DATA_W-1:0] sh, keep, ext;
  logic              mis, idle, in_req, accept, hs, abort, sgn;
  assign lane   = req_addr_i[LB-1:0];
  assign mis    = (req_size_i == 2'b01 & req_addr_i[0]) | (req_size_i == 2'b10 & |req_addr_i[1:0]) |
                  (req_size_i == 2'b11);
  assign idle   = state_q == IDLE;
  assign in_req = state_q == REQ;
  assign accept = idle & req_valid_i & !mis;
  assign hs     = in_req & mem.mem_ready;
  // ready in the limit cycle counts as a handshake, so abort only without it
  assign abort  = in_req & !mem.mem_ready & (cnt_q == CW'(TIMEOUT - 1));
  assign mask   = req_size_i == 2'b00 ? BYTES'(1) : req_size_i == 2'b01 ? BYTES'(3) : BYTES'(15);
  // load path: bring the addressed lane down to bit 0, then sign/zero extend above the access width
  always_comb begin
    sh   = mem.mem_rdata >> {lane_q, 3'b000};
    keep = size_q == 2'b00 ? DATA_W'(8'hff) : size_q == 2'b01 ? DATA_W'(16'hffff) : DATA_W'(32'hffff_ffff);
    sgn  = !uns_q & (size_q == 2'b00 ? sh[7] : size_q == 2'b01 ? sh[15] : sh[31]);
    ext  = (sh & keep) | (~keep & {DATA_W{sgn}});
  end
  always_comb begin
    state_d  = accept ? REQ : in_req ? ((hs | abort) ? RESP : REQ) : IDLE;
    cnt_d    = in_req ? cnt_q + CW'(!mem.mem_ready) : '0;
    we_d     = accept ? req_we_i : we_q;
    uns_d    = accept ? req_unsigned_i : uns_q;
    size_d   = accept ? req_size_i : size_q;
    lane_d   = accept ? lane : lane_q;
    addr_d   = accept ? {req_addr_i[ADDR_W-1:LB], {LB{1'b0}}} : addr_q;
    mem_we_d = accept ? (req_we_i ? mask << lane : '0) : mem_we_q;
    wdata_d  = accept ? req_wdata_i << {lane, 3'b000} : wdata_q;
    rdata_d  = abort ? '0 : (hs & !we_q) ? ext : rdata_q;
    rv_d     = hs & !we_q;
    to_d     = abort;
    mis_d    = idle & req_valid_i & mis;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= '0;
      lane_q   <= '0;
      addr_q   <= '0;
      mem_we_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rv_q     <= 1'b0;
      to_q     <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      mem_we_q <= mem_we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rv_q     <= rv_d;
      to_q     <= to_d;
      mis_q    <= mis_d;
    end
  end
  // gated by rst_n so a pending request cannot hold the pipeline frozen during reset
  assign stall_o       = rst_n & (accept | in_req);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rv_q;
  assign misaligned_o  = mis_q;
  assign timeout_o     = to_q;
  assign mem.mem_valid = in_req;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem_handshake.sv
// tb_lsu_mem_handshake: directed vector bench for lsu_mem_handshake
module tb_lsu_mem_handshake;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, misaligned, timeout;
  logic [31:0] rdata;
  int          n_cmp = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  lsu_mem_handshake_if #(.ADDR_W(32), .DATA_W(32)) bus();
  lsu_mem_handshake #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_we_i(req_we), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .stall_o(stall),
    .rdata_o(rdata), .rdata_valid_o(rdata_valid), .misaligned_o(misaligned), .timeout_o(timeout),
    .mem(bus)
  );
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, mrd, e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata, e_rdata;
    logic        e_rv;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic v, input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid = v; req_we = we; req_size = sz; req_uns = u; req_addr = a; req_wdata = wd;
  endtask
  task automatic run_vec(input vec_t v, input int i);
    set_req(1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    bus.mem_ready = 1'b0;
    #1;
    chk($sformatf("v%0d_stall_accept", i), stall, 1);
    chk($sformatf("v%0d_valid_idle", i), bus.mem_valid, 0);
    tick();
    chk($sformatf("v%0d_valid_req", i), bus.mem_valid, 1);
    chk($sformatf("v%0d_stall_req", i), stall, 1);
    chk($sformatf("v%0d_addr", i), bus.mem_addr, v.e_addr);
    chk($sformatf("v%0d_we", i), bus.mem_we, v.e_we);
    chk($sformatf("v%0d_wdata", i), bus.mem_wdata, v.e_wdata);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = v.mrd;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    chk($sformatf("v%0d_stall_resp", i), stall, 0);
    chk($sformatf("v%0d_valid_resp", i), bus.mem_valid, 0);
    chk($sformatf("v%0d_rvalid", i), rdata_valid, v.e_rv);
    chk($sformatf("v%0d_rdata", i), rdata, v.e_rdata);
    chk($sformatf("v%0d_timeout", i), timeout, 0);
    tick();
    chk($sformatf("v%0d_no_new_after_resp", i), bus.mem_valid, 0);
    chk($sformatf("v%0d_rvalid_drop", i), rdata_valid, 0);
    req_valid = 1'b0;
    #1;
  endtask
  task automatic mis_seq(input string nm, input logic we, input logic [1:0] sz, input logic [31:0] a);
    set_req(1'b1, we, sz, 1'b0, a, 32'h1234_5678);
    #1;
    chk({nm, "_stall"}, stall, 0);
    tick();
    chk({nm, "_pulse"}, misaligned, 1);
    chk({nm, "_valid"}, bus.mem_valid, 0);
    req_valid = 1'b0;
    tick();
    chk({nm, "_pulse_end"}, misaligned, 0);
    chk({nm, "_valid_after"}, bus.mem_valid, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vt[0] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b1};
    vt[1] = '{1'b1, 2'b00, 1'b0, 32'h203, 32'hA5, 32'h0, 32'h200, 4'b1000, 32'hA500_0000, 32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b0, 2'b00, 1'b0, 32'h302, 32'h0, 32'h12F4_5678, 32'h300, 4'b0000, 32'h0, 32'hFFFF_FFF4, 1'b1};
    vt[3] = '{1'b0, 2'b00, 1'b1, 32'h302, 32'h0, 32'h12F4_5678, 32'h300, 4'b0000, 32'h0, 32'h0000_00F4, 1'b1};
    vt[4] = '{1'b0, 2'b01, 1'b1, 32'h302, 32'h0, 32'h12F4_5678, 32'h300, 4'b0000, 32'h0, 32'h0000_12F4, 1'b1};
    vt[5] = '{1'b0, 2'b01, 1'b0, 32'h300, 32'h0, 32'h12F4_8678, 32'h300, 4'b0000, 32'h0, 32'hFFFF_8678, 1'b1};
    vt[6] = '{1'b1, 2'b01, 1'b0, 32'h402, 32'h1234, 32'h0, 32'h400, 4'b1100, 32'h1234_0000, 32'hFFFF_8678, 1'b0};
    vt[7] = '{1'b1, 2'b10, 1'b0, 32'h500, 32'hCAFE_F00D, 32'h0, 32'h500, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_8678, 1'b0};
    vt[8] = '{1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h0000_7F00, 32'h100, 4'b0000, 32'h0, 32'h0000_007F, 1'b1};
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'hFFFF_FFFF);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_valid", bus.mem_valid, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_timeout", timeout, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    tick();
    chk("idle_ready_valid", bus.mem_valid, 0);
    chk("idle_ready_rvalid", rdata_valid, 0);
    chk("idle_ready_rdata", rdata, 0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) run_vec(vt[i], i);
    mis_seq("mis_lh401", 1'b0, 2'b01, 32'h401);
    mis_seq("mis_size11", 1'b0, 2'b11, 32'h100);
    mis_seq("mis_sw502", 1'b1, 2'b10, 32'h502);
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0);
    #1;
    chk("to_stall_accept", stall, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_valid_c%0d", k), bus.mem_valid, 1);
      chk($sformatf("to_no_pulse_c%0d", k), timeout, 0);
      tick();
    end
    chk("to_pulse", timeout, 1);
    chk("to_rdata_zero", rdata, 0);
    chk("to_rvalid", rdata_valid, 0);
    chk("to_valid_drop", bus.mem_valid, 0);
    chk("to_stall_resp", stall, 0);
    tick();
    req_valid = 1'b0;
    chk("to_pulse_end", timeout, 0);
    chk("to_idle_valid", bus.mem_valid, 0);
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h700, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("r4_valid_c%0d", k), bus.mem_valid, 1);
      tick();
    end
    chk("r4_valid_c3", bus.mem_valid, 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1122_3344;
    tick();
    bus.mem_ready = 1'b0;
    chk("r4_no_timeout", timeout, 0);
    chk("r4_rvalid", rdata_valid, 1);
    chk("r4_rdata", rdata, 32'h1122_3344);
    tick();
    req_valid = 1'b0;
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h800, 32'h0);
    tick();
    chk("rst_mid_valid_before", bus.mem_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.mem_valid, 0);
    chk("rst_mid_stall", stall, 0);
    tick();
    chk("rst_mid_timeout", timeout, 0);
    chk("rst_mid_rvalid", rdata_valid, 0);
    chk("rst_mid_mis", misaligned, 0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_vec(vt[0], 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
